// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stack_ctrl
// Brief    : Stack-pointer controller for a two-port asynchronous-read stack
//            RAM. Keeps the top of stack in a register, spills older entries
//            to RAM, and reports depth, full/empty and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module stack_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  replace,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] tos,
  output logic [DATA_WIDTH-1:0] nos,
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  // Capacity counts every RAM word plus the TOS register.
  localparam logic [ADDR_WIDTH:0] CAP       = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_TWO = (ADDR_WIDTH+1)'(2);

  logic [ADDR_WIDTH-1:0] sp,        sp_nx;
  logic [DATA_WIDTH-1:0] tos_q,     tos_nx;
  logic [ADDR_WIDTH:0]   depth_q,   depth_nx;
  logic                  ovf_q,     unf_q;
  logic                  ovf_set,   unf_set;
  logic                  wr_req;
  logic                  is_empty,  is_full;
  logic                  do_replace;

  assign is_empty   = (depth_q == '0);
  assign is_full    = (depth_q == CAP);
  // push together with pop collapses into an in-place overwrite of TOS.
  assign do_replace = replace | (push & pop);

  // Operation decode: next pointer, TOS, depth and error events.
  always_comb begin
    sp_nx    = sp;
    tos_nx   = tos_q;
    depth_nx = depth_q;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    wr_req   = 1'b0;
    if (do_replace) begin
      if (is_empty) unf_set = 1'b1;
      else          tos_nx  = in_data;
    end else if (push) begin
      if (is_empty) begin
        tos_nx   = in_data;
        depth_nx = DEPTH_ONE;
      end else if (is_full) begin
        ovf_set  = 1'b1;
      end else begin
        // Spill current TOS into the word just above NOS.
        wr_req   = 1'b1;
        sp_nx    = sp + 1'b1;
        tos_nx   = in_data;
        depth_nx = depth_q + 1'b1;
      end
    end else if (pop) begin
      if (is_empty) begin
        unf_set  = 1'b1;
      end else if (depth_q == DEPTH_ONE) begin
        tos_nx   = '0;
        depth_nx = '0;
      end else begin
        // Refill TOS from NOS, which the RAM presents combinationally.
        tos_nx   = ram_rd_data;
        sp_nx    = sp - 1'b1;
        depth_nx = depth_q - 1'b1;
      end
    end
  end

  // Stack state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp      <= '1;
      tos_q   <= '0;
      depth_q <= '0;
    end else begin
      sp      <= sp_nx;
      tos_q   <= tos_nx;
      depth_q <= depth_nx;
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~clr_err);
      unf_q <= unf_set | (unf_q & ~clr_err);
    end
  end

  assign tos         = tos_q;
  assign depth       = depth_q;
  assign empty       = is_empty;
  assign full        = is_full;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign nos         = (depth_q >= DEPTH_TWO) ? ram_rd_data : '0;
  assign ram_rd_addr = sp;
  assign ram_wr_addr = sp + 1'b1;
  assign ram_wr_data = tos_q;
  assign ram_wr_en   = wr_req & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_ctrl
// Brief    : Directed self-checking bench for stack_ctrl (ADDR_WIDTH=2, CAP=5)
//            with a queue-based reference stack and a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_ctrl;
  localparam int AW  = 2;
  localparam int DW  = 16;
  localparam int CAP = (1 << AW) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0, pop = 1'b0, replace = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] tos, nos, ram_wr_data, ram_rd_data;
  logic [AW:0]   depth;
  logic          empty, full, overflow, underflow, ram_wr_en;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;

  int total = 0;
  int passed = 0;

  stack_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .replace(replace),
    .in_data(in_data), .clr_err(clr_err), .tos(tos), .nos(nos),
    .depth(depth), .empty(empty), .full(full), .overflow(overflow),
    .underflow(underflow), .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr),
    .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural stack RAM: asynchronous read, synchronous write.
  logic [DW-1:0] mem [1 << AW];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
  assign ram_rd_data = mem[ram_rd_addr];
  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;

  // Reference model: element 0 is the top of the stack.
  logic [DW-1:0] stk [$];
  bit            m_ovf = 1'b0, m_unf = 1'b0;

  always @(posedge clk or posedge rst) begin
    bit e_o, e_u;
    if (rst) begin
      stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      e_o = 1'b0;
      e_u = 1'b0;
      if (replace || (push && pop)) begin
        if (stk.size() == 0) e_u = 1'b1;
        else                 stk[0] = in_data;
      end else if (push) begin
        if (stk.size() == CAP) e_o = 1'b1;
        else                   stk.push_front(in_data);
      end else if (pop) begin
        if (stk.size() == 0) e_u = 1'b1;
        else                 void'(stk.pop_front());
      end
      m_ovf = e_o || (m_ovf && !clr_err);
      m_unf = e_u || (m_unf && !clr_err);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of every observable output against the model.
  always @(negedge clk) begin
    logic [DW-1:0] e_tos, e_nos;
    bit e_wr;
    e_tos = (stk.size() > 0) ? stk[0] : '0;
    e_nos = (stk.size() > 1) ? stk[1] : '0;
    e_wr  = !rst && push && !pop && !replace && stk.size() >= 1 && stk.size() < CAP;
    chk("tos",       32'(tos),       32'(e_tos));
    chk("nos",       32'(nos),       32'(e_nos));
    chk("depth",     32'(depth),     32'(stk.size()));
    chk("empty",     32'(empty),     32'(stk.size() == 0));
    chk("full",      32'(full),      32'(stk.size() == CAP));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("wr_en",     32'(ram_wr_en), 32'(e_wr));
  end

  // Drive one op for one clock; returns 1 time unit after the edge.
  task automatic cyc(input bit p, input bit q, input bit r, input logic [DW-1:0] d, input bit c);
    push = p; pop = q; replace = r; in_data = d; clr_err = c;
    @(posedge clk); #1;
    push = 0; pop = 0; replace = 0; in_data = '0; clr_err = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    #12 rst = 1'b0;
    // Reset state
    chk("rst_tos",   32'(tos),         32'h0);
    chk("rst_depth", 32'(depth),       32'h0);
    chk("rst_empty", 32'(empty),       32'h1);
    chk("rst_sp",    32'(ram_rd_addr), 32'h3);

    // Three pushes spill two entries to RAM
    cyc(1, 0, 0, 16'h11, 0);
    cyc(1, 0, 0, 16'h22, 0);
    cyc(1, 0, 0, 16'h33, 0);
    chk("p3_tos",   32'(tos),         32'h33);
    chk("p3_nos",   32'(nos),         32'h22);
    chk("p3_depth", 32'(depth),       32'h3);
    chk("p3_mem0",  32'(mem[0]),      32'h11);
    chk("p3_mem1",  32'(mem[1]),      32'h22);
    chk("p3_sp",    32'(ram_rd_addr), 32'h1);
    repeat (3) cyc(0, 1, 0, 16'h0, 0);
    chk("drain_empty", 32'(empty), 32'h1);

    // Fill to capacity, then overflow
    for (int i = 1; i <= 5; i++) cyc(1, 0, 0, DW'(i), 0);
    chk("fill_full", 32'(full), 32'h1);
    cyc(1, 0, 0, 16'h6, 0);
    chk("ovf_flag",  32'(overflow), 32'h1);
    chk("ovf_tos",   32'(tos),      32'h5);
    chk("ovf_depth", 32'(depth),    32'h5);

    // Pop down to empty, then underflow
    for (int i = 4; i >= 0; i--) begin
      cyc(0, 1, 0, 16'h0, 0);
      chk("pop_tos", 32'(tos), 32'(i));
    end
    chk("pop_empty", 32'(empty), 32'h1);
    cyc(0, 1, 0, 16'h0, 0);
    chk("unf_flag",  32'(underflow), 32'h1);
    chk("unf_depth", 32'(depth),     32'h0);

    // push&pop behaves as replace
    cyc(0, 0, 0, 16'h0, 1);
    cyc(1, 0, 0, 16'h31, 0);
    cyc(1, 0, 0, 16'h32, 0);
    cyc(1, 0, 0, 16'h33, 0);
    cyc(1, 1, 0, 16'hAA, 0);
    chk("rep_tos",   32'(tos),         32'hAA);
    chk("rep_depth", 32'(depth),       32'h3);
    chk("rep_sp",    32'(ram_rd_addr), 32'h1);
    cyc(0, 0, 1, 16'hBB, 0);
    chk("rep2_tos",  32'(tos),         32'hBB);

    // Error set in the clearing cycle wins; plain clear then drops it
    cyc(1, 0, 0, 16'h34, 0);
    cyc(1, 0, 0, 16'h35, 0);
    cyc(1, 0, 0, 16'h36, 1);
    chk("clr_ovf_wins", 32'(overflow), 32'h1);
    chk("clr_ovf_tos",  32'(tos),      32'h35);
    cyc(0, 0, 0, 16'h0, 1);
    chk("clr_ovf_done", 32'(overflow), 32'h0);

    // Re-arm overflow, drop to depth 2, then reset asynchronously during a push
    cyc(1, 0, 0, 16'h37, 0);
    repeat (3) cyc(0, 1, 0, 16'h0, 0);
    chk("pre_rst_depth", 32'(depth), 32'h2);
    push = 1'b1; in_data = 16'h99;
    #3 rst = 1'b1;
    #1;
    chk("arst_tos",   32'(tos),       32'h0);
    chk("arst_depth", 32'(depth),     32'h0);
    chk("arst_ovf",   32'(overflow),  32'h0);
    chk("arst_wr_en", 32'(ram_wr_en), 32'h0);
    @(posedge clk); #1;
    push = 1'b0; in_data = '0;
    #3 rst = 1'b0;
    cyc(1, 0, 0, 16'h7, 0);
    chk("post_rst_tos",   32'(tos),   32'h7);
    chk("post_rst_depth", 32'(depth), 32'h1);

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Stack-pointer controller for the two-port, asynchronous-read stack RAM used by the CPU evaluation stack.
- Owns the stack pointer and holds the top-of-stack (TOS) in a register.
- Drives the RAM read/write address, write enable and write data. Receives RAM read data to refill TOS on pop.
- Presents TOS, next-of-stack (NOS), depth, full/empty and sticky overflow/underflow flags to the datapath.

Parameters:
- ADDR_WIDTH, 4, RAM address width; RAM holds 2**ADDR_WIDTH entries; total capacity CAP = 2**ADDR_WIDTH+1 (RAM plus TOS register).
- DATA_WIDTH, 16, stack element width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  push in_data.
- pop  in  1  discard TOS.
- replace  in  1  overwrite TOS with in_data.
- in_data  in  DATA_WIDTH  data for push/replace.
- clr_err  in  1  clear the sticky error flags.
- tos  out  DATA_WIDTH  top of stack (registered).
- nos  out  DATA_WIDTH  next of stack (combinational).
- depth  out  ADDR_WIDTH+1  element count, 0..CAP (registered).
- empty  out  1  depth==0.
- full  out  1  depth==CAP.
- overflow  out  1  sticky.
- underflow  out  1  sticky.
- ram_rd_addr  out  ADDR_WIDTH  to RAM read address.
- ram_wr_addr  out  ADDR_WIDTH  to RAM write address.
- ram_wr_en  out  1  to RAM write enable.
- ram_wr_data  out  DATA_WIDTH  to RAM write data.
- ram_rd_data  in  DATA_WIDTH  from RAM, same-cycle (asynchronous) read.

Behaviour:
- Reset is asynchronous and active-high, applied through rst; a single clock clk. Reset values: sp=all ones, depth=0, tos=0, overflow=0, underflow=0. Reset mid-operation aborts any pending op; no RAM write occurs while rst is high.
- sp is an internal ADDR_WIDTH register that points at the RAM word holding NOS. It wraps modulo 2**ADDR_WIDTH, so the first spill lands at address 0.
- ram_rd_addr = sp at all times. ram_wr_addr = sp+1 (mod 2**ADDR_WIDTH). ram_wr_data = tos.
- nos = ram_rd_data when depth>=2, else 0.
- ram_wr_en is combinational and is 1 only in the cycle of an accepted push with depth>=1.
- Op decode, in priority order, one op per cycle, single-cycle latency (new tos/depth visible the cycle after the edge):
  - push&pop, or replace: treated as REPLACE. If depth>=1, tos<=in_data; sp and depth unchanged. If depth==0, set underflow; no change.
  - push only, depth==0: tos<=in_data, depth<=1, no RAM write, sp unchanged.
  - push only, 1<=depth<CAP: RAM[sp+1]<=tos, sp<=sp+1, tos<=in_data, depth+1.
  - push only, depth==CAP: set overflow; tos, sp, depth and RAM unchanged.
  - pop only, depth>=2: tos<=ram_rd_data, sp<=sp-1, depth-1.
  - pop only, depth==1: tos<=0, depth<=0, sp unchanged.
  - pop only, depth==0: set underflow; no change.
  - none: hold.
- Sticky flags: an error set in the same cycle as clr_err wins (the flag reads 1). Otherwise clr_err clears both flags.
- Errors never corrupt the stack; the rejected op is simply dropped.
- empty and full are decoded from the registered depth and are glitch-free relative to clk.

Test Plan:
- Reset, then ADDR_WIDTH=2: push 0x11,0x22,0x33 -> tos=0x33, nos=0x22, depth=3, RAM[0]=0x11, RAM[1]=0x22, sp=1.
- Push 5 values 1..5 (CAP=5) -> full=1. A 6th push of 6 -> overflow=1, tos=5, depth=5, no ram_wr_en pulse.
- From full, pop x5 -> tos sequence 4,3,2,1,0; empty=1. A further pop -> underflow=1, depth=0.
- Depth 3, assert push&pop with in_data=0xAA -> tos=0xAA, depth=3, sp unchanged, ram_wr_en=0.
- Set overflow, then assert clr_err with a simultaneous overflowing push -> overflow stays 1. clr_err alone on the next cycle -> overflow=0.
- Assert rst asynchronously mid-cycle during a push at depth 2 -> tos=0, depth=0, flags=0 immediately. Subsequent push 0x7 -> tos=7, depth=1, no RAM write.
